// File: rtl/chiplib_pri_queue_pkg.sv
// Shared definitions for the priority-queue push arbiter and its helpers.
package chiplib_pri_queue_pkg;

  localparam int unsigned StarveCntWidth = 8;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 3) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/chiplib_rr_pick.sv
// Round-robin first-one search over a candidate mask, starting at i_ptr with wrap.
module chiplib_rr_pick #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdWidth = 2
) (
  input  logic [NumReq-1:0]  i_cand,
  input  logic [IdWidth-1:0] i_ptr,
  output logic [NumReq-1:0]  o_grant_c
);

  logic w_found;

  // First pass covers ptr..NumReq-1, second pass wraps to 0..ptr-1.
  always_comb begin
    o_grant_c = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && i_cand[i] && (IdWidth'(i) >= i_ptr)) begin
        o_grant_c[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!w_found && i_cand[i]) begin
        o_grant_c[i] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chiplib_pri_queue_push_arb.sv
// Priority arbiter with round-robin tie-break and starvation override feeding a
// single registered push stage of a priority queue.
module chiplib_pri_queue_push_arb
  import chiplib_pri_queue_pkg::*;
#(
  parameter  int unsigned NumReq        = 4,
  parameter  int unsigned DataWidth     = 64,
  parameter  int unsigned PriorityWidth = 16,
  parameter  int unsigned StarveLimit   = 15,
  localparam int unsigned IdWidth       = id_width(NumReq)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumReq*DataWidth-1:0]       req_data,
  input  logic [NumReq*PriorityWidth-1:0]   req_pri,
  input  logic [NumReq-1:0]                 req_valid,
  output logic [NumReq-1:0]                 req_ready,
  output logic [DataWidth-1:0]              out_data,
  output logic [PriorityWidth-1:0]          out_pri,
  output logic [IdWidth-1:0]                out_id,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int unsigned CntWidth = StarveCntWidth;
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(StarveLimit);

  logic [DataWidth-1:0]                r_out_data;
  logic [PriorityWidth-1:0]            r_out_pri;
  logic [IdWidth-1:0]                  r_out_id;
  logic                                r_out_valid;
  logic [IdWidth-1:0]                  r_rr_ptr;
  logic [NumReq-1:0][CntWidth-1:0]     r_starve_cnt;

  logic                                w_accept;
  logic [PriorityWidth-1:0]            w_max_pri;
  logic [NumReq-1:0]                   w_starving;
  logic [NumReq-1:0]                   w_top_pri;
  logic [NumReq-1:0]                   w_cand;
  logic [NumReq-1:0]                   w_grant;
  logic                                w_any_grant;
  logic [IdWidth-1:0]                  w_grant_id;
  logic [IdWidth-1:0]                  w_next_ptr;
  logic [DataWidth-1:0]                w_sel_data;
  logic [PriorityWidth-1:0]            w_sel_pri;

  assign w_accept = (!r_out_valid || out_ready) && !rst;

  // Candidate set: starving requesters override, else the highest-priority valid ones.
  always_comb begin
    w_max_pri  = '0;
    w_starving = '0;
    w_top_pri  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (req_valid[i] && (req_pri[i*PriorityWidth +: PriorityWidth] > w_max_pri)) begin
        w_max_pri = req_pri[i*PriorityWidth +: PriorityWidth];
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      w_starving[i] = req_valid[i] && (r_starve_cnt[i] == StarveMax);
      w_top_pri[i]  = req_valid[i] && (req_pri[i*PriorityWidth +: PriorityWidth] == w_max_pri);
    end
  end

  assign w_cand = !w_accept ? '0 : ((|w_starving) ? w_starving : w_top_pri);

  chiplib_rr_pick #(
    .NumReq  (NumReq),
    .IdWidth (IdWidth)
  ) u_rr_pick (
    .i_cand    (w_cand),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_grant)
  );

  assign req_ready   = w_grant;
  assign w_any_grant = |w_grant;

  // One-hot grant to index plus payload mux; data never feeds back into req_ready.
  always_comb begin
    w_grant_id = '0;
    w_sel_data = '0;
    w_sel_pri  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_grant[i]) begin
        w_grant_id = IdWidth'(i);
        w_sel_data = req_data[i*DataWidth +: DataWidth];
        w_sel_pri  = req_pri[i*PriorityWidth +: PriorityWidth];
      end
    end
  end

  assign w_next_ptr = (w_grant_id == IdWidth'(NumReq - 1)) ? '0 : (w_grant_id + IdWidth'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_pri   <= '0;
      r_out_id    <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_any_grant) begin
      r_out_data  <= w_sel_data;
      r_out_pri   <= w_sel_pri;
      r_out_id    <= w_grant_id;
      r_out_valid <= 1'b1;
      r_rr_ptr    <= w_next_ptr;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Waiting time per requester; a stalled output stage still counts as waiting.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumReq; i++) begin
      if (rst || !req_valid[i] || w_grant[i]) begin
        r_starve_cnt[i] <= '0;
      end else if (r_starve_cnt[i] != StarveMax) begin
        r_starve_cnt[i] <= r_starve_cnt[i] + CntWidth'(1);
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_pri   = r_out_pri;
  assign out_id    = r_out_id;
  assign out_valid = r_out_valid;

endmodule
